// File: rtl/fp16_addsub_sequencer.sv
// Multi-cycle FP16 add/subtract sequencer: unpack, align through an external
// right-shifter, add/sub, normalize one bit per cycle, then pack (truncating).
module fp16_addsub_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [10:0] shf_in,
  output logic [4:0]  shf_ctrl,
  input  logic [10:0] shf_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_PACK
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [15:0] r_a;
  logic [15:0] r_b;
  logic        r_op;
  logic        r_sx;
  logic        r_sy;
  logic [4:0]  r_ex;
  logic [10:0] r_mx;
  logic [10:0] r_my;
  logic [4:0]  r_shf_ctrl;
  logic [10:0] r_mys;
  logic [11:0] r_sum;
  logic [5:0]  r_exp;
  logic        r_sign;
  logic        r_special;
  logic [15:0] r_spec_val;
  logic [15:0] r_result;
  logic        r_done;

  // Unpack view of the latched operands
  logic        w_sa;
  logic        w_sb;
  logic [4:0]  w_ea;
  logic [4:0]  w_eb;
  logic [10:0] w_ma;
  logic [10:0] w_mb;
  logic        w_a_spec;
  logic        w_b_spec;
  logic        w_special;
  logic        w_swap;
  logic [4:0]  w_ex_sel;
  logic [4:0]  w_ey_sel;
  logic [4:0]  w_diff;
  logic [4:0]  w_shamt;
  logic [11:0] w_sum;
  logic        w_norm_zero;
  logic        w_norm_ovf;
  logic        w_norm_ok;
  logic        w_norm_flush;
  logic        w_norm_exit;

  assign w_sa      = r_a[15];
  assign w_sb      = r_b[15] ^ r_op;
  assign w_ea      = r_a[14:10];
  assign w_eb      = r_b[14:10];
  assign w_ma      = (w_ea == 5'd0) ? 11'd0 : {1'b1, r_a[9:0]};
  assign w_mb      = (w_eb == 5'd0) ? 11'd0 : {1'b1, r_b[9:0]};
  assign w_a_spec  = (w_ea == 5'h1F);
  assign w_b_spec  = (w_eb == 5'h1F);
  assign w_special = w_a_spec | w_b_spec;
  // Strict compare keeps A as the larger operand on a magnitude tie
  assign w_swap    = (r_b[14:0] > r_a[14:0]);
  assign w_ex_sel  = w_swap ? w_eb : w_ea;
  assign w_ey_sel  = w_swap ? w_ea : w_eb;
  assign w_diff    = w_ex_sel - w_ey_sel;
  assign w_shamt   = (w_diff > 5'd16) ? 5'd16 : w_diff;

  assign w_sum = (r_sx == r_sy) ? ({1'b0, r_mx} + {1'b0, r_mys})
                                : ({1'b0, r_mx} - {1'b0, r_mys});

  assign w_norm_zero  = (r_sum == 12'd0);
  assign w_norm_ovf   = r_sum[11];
  assign w_norm_ok    = r_sum[10];
  assign w_norm_flush = (r_exp == 6'd1);
  assign w_norm_exit  = w_norm_zero | w_norm_ovf | w_norm_ok | w_norm_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_next = S_UNPACK;
      S_UNPACK: w_state_next = w_special ? S_PACK : S_ALIGN;
      S_ALIGN:  w_state_next = S_ADD;
      S_ADD:    w_state_next = S_NORM;
      S_NORM:   if (w_norm_exit) w_state_next = S_PACK;
      S_PACK:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= 1'b0;
      r_sx       <= 1'b0;
      r_sy       <= 1'b0;
      r_ex       <= '0;
      r_mx       <= '0;
      r_my       <= '0;
      r_shf_ctrl <= '0;
      r_mys      <= '0;
      r_sum      <= '0;
      r_exp      <= '0;
      r_sign     <= 1'b0;
      r_special  <= 1'b0;
      r_spec_val <= '0;
      r_result   <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a       <= a;
            r_b       <= b;
            r_op      <= op;
            r_special <= 1'b0;
          end
        end
        S_UNPACK: begin
          if (w_special) begin
            r_special  <= 1'b1;
            r_spec_val <= w_a_spec ? r_a : r_b;
          end else begin
            r_sx       <= w_swap ? w_sb : w_sa;
            r_sy       <= w_swap ? w_sa : w_sb;
            r_ex       <= w_ex_sel;
            r_mx       <= w_swap ? w_mb : w_ma;
            r_my       <= w_swap ? w_ma : w_mb;
            r_shf_ctrl <= w_shamt;
          end
        end
        S_ALIGN: begin
          r_mys <= shf_out;
        end
        S_ADD: begin
          r_sum  <= w_sum;
          r_sign <= r_sx;
          r_exp  <= {1'b0, r_ex};
        end
        S_NORM: begin
          if (w_norm_zero) begin
            r_sign <= 1'b0;
            r_exp  <= '0;
          end else if (w_norm_ovf) begin
            r_sum <= {1'b0, r_sum[11:1]};
            r_exp <= r_exp + 6'd1;
          end else if (w_norm_ok) begin
            r_sum <= r_sum;
          end else if (w_norm_flush) begin
            r_sum <= '0;
            r_exp <= '0;
          end else begin
            r_sum <= {r_sum[10:0], 1'b0};
            r_exp <= r_exp - 6'd1;
          end
        end
        S_PACK: begin
          r_done <= 1'b1;
          if (r_special) begin
            r_result <= r_spec_val;
          end else if (r_exp >= 6'd31) begin
            r_result <= {r_sign, 5'h1F, 10'h000};
          end else begin
            r_result <= {r_sign, r_exp[4:0], r_sum[9:0]};
          end
        end
        default: r_done <= 1'b0;
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign result   = r_result;
  assign shf_in   = (r_state == S_ALIGN) ? r_my : 11'd0;
  assign shf_ctrl = (r_state == S_ALIGN) ? r_shf_ctrl : 5'd0;

endmodule

// File: tb/tb_fp16_addsub_sequencer.sv
// Bench for fp16_addsub_sequencer: directed and random operations checked
// against an integer-arithmetic reference model, plus reset and handshake cases.
module tb_fp16_addsub_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [10:0] shf_in;
  logic [4:0]  shf_ctrl;
  logic [10:0] shf_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // External shifter: right shift, 16 or more clears everything
  assign shf_out = (shf_ctrl >= 5'd16) ? 11'd0 : (shf_in >> shf_ctrl);

  fp16_addsub_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .shf_in   (shf_in),
    .shf_ctrl (shf_ctrl),
    .shf_out  (shf_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pack(input bit s, input int e, input int m);
    if (e >= 31) return {s, 5'h1F, 10'h000};
    return {s, 5'(e), 10'(m % 1024)};
  endfunction

  function automatic void model(input logic [15:0] xa, input logic [15:0] xb, input logic xop,
                                output logic [15:0] res, output int lat,
                                output int shamt, output int shin);
    int ea, eb, ma, mb, ex, ey, mx, my, d, sum, e, k;
    bit sa, sb, sx, sy;
    ea = int'(xa[14:10]);
    eb = int'(xb[14:10]);
    ma = (ea == 0) ? 0 : 1024 + int'(xa[9:0]);
    mb = (eb == 0) ? 0 : 1024 + int'(xb[9:0]);
    sa = xa[15];
    sb = xb[15] ^ xop;
    shamt = 0;
    shin  = 0;
    res   = 16'h0000;
    lat   = 2;
    if (ea == 31) begin res = xa; return; end
    if (eb == 31) begin res = xb; return; end
    if (xb[14:0] > xa[14:0]) begin
      ex = eb; mx = mb; sx = sb; ey = ea; my = ma; sy = sa;
    end else begin
      ex = ea; mx = ma; sx = sa; ey = eb; my = mb; sy = sb;
    end
    d     = ex - ey;
    shamt = (d > 16) ? 16 : d;
    shin  = my;
    my    = (d >= 16) ? 0 : my / (1 << d);
    sum   = (sx == sy) ? mx + my : mx - my;
    e = ex;
    k = 0;
    for (int i = 0; i < 12; i++) begin
      if (sum == 0) begin res = 16'h0000; break; end
      if (sum >= 2048) begin res = pack(sx, e + 1, sum / 2); break; end
      if (sum >= 1024) begin res = pack(sx, e, sum); break; end
      if (e == 1) begin res = {sx, 15'h0000}; break; end
      sum = sum * 2;
      e   = e - 1;
      k   = k + 1;
    end
    lat = 5 + k;
  endfunction

  // Starts from #1 after an edge with the DUT idle or in its done cycle.
  task automatic run_op(input logic [15:0] xa, input logic [15:0] xb, input logic xop,
                        input bit pulse, output logic [15:0] r, output int lat,
                        output int sc, output int si, output int busy_fall);
    a = xa; b = xb; op = xop; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_edge0", {31'd0, busy}, 32'd1);
    check("shf_ctrl_unpack", {27'd0, shf_ctrl}, 32'd0);
    lat = -1; sc = -1; si = -1; busy_fall = -1; r = 16'hxxxx;
    for (int n = 1; n <= 40; n++) begin
      if (pulse && n == 2) begin
        start = 1'b1;
        a = 16'h1234;
        b = 16'h5678;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (n == 1) begin sc = int'(shf_ctrl); si = int'(shf_in); end
      if (!busy && busy_fall < 0) busy_fall = n;
      if (done) begin lat = n; r = result; break; end
    end
  endtask

  task automatic run_and_check(input logic [15:0] xa, input logic [15:0] xb, input logic xop,
                               input bit pulse, input bit use_hard,
                               input logic [15:0] hard_res, input int hard_lat);
    logic [15:0] eres, r;
    int elat, esc, esi, lat, sc, si, bf;
    model(xa, xb, xop, eres, elat, esc, esi);
    run_op(xa, xb, xop, pulse, r, lat, sc, si, bf);
    check("done_latency", lat, elat);
    check("result", {16'd0, r}, {16'd0, eres});
    check("busy_falls_with_done", bf, elat);
    check("shf_ctrl_align", sc, esc);
    check("shf_in_align", si, esi);
    if (use_hard) begin
      check("result_directed", {16'd0, r}, {16'd0, hard_res});
      check("latency_directed", lat, hard_lat);
    end
    $display("[TB] a=%h b=%h op=%0d -> result=%h lat=%0d shf_ctrl=%0d", xa, xb, xop, r, lat, sc);
  endtask

  logic [15:0] d_a   [14] = '{16'h3C00, 16'h3E00, 16'h3C00, 16'h6400, 16'h3C00, 16'h7800, 16'h2C00,
                              16'h7BFF, 16'h7C00, 16'h3C00, 16'h0401, 16'h0800, 16'h3C01, 16'h3E00};
  logic [15:0] d_b   [14] = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h6400, 16'h2C00, 16'h7800,
                              16'h7BFF, 16'h3C00, 16'h0001, 16'h0400, 16'h07FF, 16'h3C00, 16'h3C00};
  logic        d_op  [14] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [15:0] d_res [14] = '{16'h4000, 16'h3800, 16'h0000, 16'h6401, 16'h6401, 16'h7800, 16'h7800,
                              16'h7C00, 16'h7C00, 16'h3C00, 16'h0000, 16'h0000, 16'h1400, 16'h3800};
  int          d_lat [14] = '{5, 6, 5, 5, 5, 5, 5, 5, 2, 5, 5, 6, 15, 6};
  bit          d_pls [14] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  initial begin
    logic [15:0] ra, rb, held;
    logic        rop;
    int          ea, eb, gap;
    bit          saw_done;

    rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", {16'd0, result}, 32'd0);
    check("reset_shf_in", {21'd0, shf_in}, 32'd0);
    check("reset_shf_ctrl", {27'd0, shf_ctrl}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      run_and_check(d_a[i], d_b[i], d_op[i], d_pls[i], 1'b1, d_res[i], d_lat[i]);
    end

    held = result;
    repeat (3) @(posedge clk);
    #1;
    check("idle_no_done", {31'd0, done}, 32'd0);
    check("idle_not_busy", {31'd0, busy}, 32'd0);
    check("result_held", {16'd0, result}, {16'd0, held});

    for (int i = 0; i < 150; i++) begin
      ea  = $urandom_range(0, 30);
      eb  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 30)
                                        : ((ea + $urandom_range(0, 4) > 30) ? 30 : ea + $urandom_range(0, 4) - 2 < 0 ? 0 : ea + $urandom_range(0, 2));
      ra  = {1'($urandom), 5'(ea), 10'($urandom)};
      rb  = {1'($urandom), 5'(eb), 10'($urandom)};
      rop = 1'($urandom);
      if ($urandom_range(0, 19) == 0) ra[14:10] = 5'h1F;
      run_and_check(ra, rb, rop, ($urandom_range(0, 4) == 0), 1'b0, 16'h0, 0);
      gap = $urandom_range(0, 2);
      repeat (gap) @(posedge clk);
      if (gap > 0) begin
        #1;
        check("gap_no_done", {31'd0, done}, 32'd0);
      end
    end

    // Reset asserted while normalizing a long (k=10) operation
    run_and_check(16'h3C00, 16'h3C00, 1'b0, 1'b0, 1'b1, 16'h4000, 5);
    a = 16'h3C01; b = 16'h3C00; op = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("busy_in_norm", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_done", {31'd0, done}, 32'd0);
    check("async_rst_result", {16'd0, result}, 32'd0);
    check("async_rst_shf_in", {21'd0, shf_in}, 32'd0);
    check("async_rst_shf_ctrl", {27'd0, shf_ctrl}, 32'd0);
    saw_done = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check("no_done_after_reset", {31'd0, saw_done}, 32'd0);
    check("result_cleared", {16'd0, result}, 32'd0);
    run_and_check(16'h3C01, 16'h3C00, 1'b1, 1'b0, 1'b1, 16'h1400, 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
